x2_accurate_mul: RTL and testbench



---
 rtl/pico_mul_pkg.sv | 8 +
 rtl/half_adder.sv | 12 +
 rtl/x2_accurate_mul.sv | 56 +++++
 tb/tb_x2_accurate_mul.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pico_mul_pkg.sv
// Shared constants for the PicoMul 2x2 multiplier family.
package pico_mul_pkg;

    localparam int unsigned W        = 2;
    localparam int unsigned PW       = 2 * W;
    localparam int unsigned MAX_PROD = 9;

endpackage : pico_mul_pkg

// File: rtl/half_adder.sv
// Single-bit half adder used to sum partial-product columns.
module half_adder (
    input  logic x,
    input  logic y,
    output logic sum,
    output logic carry
);

    assign sum   = x ^ y;
    assign carry = x & y;

endmodule : half_adder

// File: rtl/x2_accurate_mul.sv
// Exact 2x2 unsigned multiplier: combinational product plus a one-stage
// registered product with valid flag.
module x2_accurate_mul
    import pico_mul_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          in_valid,
    output logic [PW-1:0] out,
    output logic [PW-1:0] out_q,
    output logic          out_valid
);

    logic pp00, pp01, pp10, pp11;
    logic s1, c1, s2, c2;

    // AND array of partial products.
    assign pp00 = a[0] & b[0];
    assign pp01 = a[0] & b[1];
    assign pp10 = a[1] & b[0];
    assign pp11 = a[1] & b[1];

    half_adder u_ha_col1 (
        .x     (pp10),
        .y     (pp01),
        .sum   (s1),
        .carry (c1)
    );

    half_adder u_ha_col2 (
        .x     (pp11),
        .y     (c1),
        .sum   (s2),
        .carry (c2)
    );

    assign out = {c2, s2, s1, pp00};

    // Capture stage; out_q holds its value across bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_q <= out;
            end
        end
    end

    a_max_prod : assert property (@(posedge clk) out <= PW'(MAX_PROD));

endmodule : x2_accurate_mul

// File: tb/tb_x2_accurate_mul.sv
// Directed self-checking bench for x2_accurate_mul.
module tb_x2_accurate_mul;

    logic       clk;
    logic       rst_n;
    logic [1:0] a;
    logic [1:0] b;
    logic       in_valid;
    logic [3:0] out;
    logic [3:0] out_q;
    logic       out_valid;

    int n_tests;
    int n_fail;

    x2_accurate_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one clock; leave time for registered outputs to settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] spot_a [5] = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd1};
    logic [1:0] spot_b [5] = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd1};
    logic [3:0] spot_p [5] = '{4'b0000, 4'b0110, 4'b0110, 4'b1001, 4'b0001};

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 2'd0;
        b        = 2'd0;

        // Exhaustive combinational sweep, a outer, b inner.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a = 2'(i);
                b = 2'(j);
                #10;
                check($sformatf("sweep %0dx%0d", i, j), 8'(out), 8'(i * j));
            end
        end
        for (int k = 0; k < 5; k++) begin
            a = spot_a[k];
            b = spot_b[k];
            #10;
            check($sformatf("spot %0d", k), 8'(out), 8'(spot_p[k]));
        end

        // Reset held with valid input: register stays cleared.
        tick();
        in_valid = 1'b1;
        a = 2'd3;
        b = 2'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst out", 8'(out), 8'b1001);
            check("rst out_q", 8'(out_q), 8'b0000);
            check("rst out_valid", 8'(out_valid), 8'd0);
        end

        // Pipeline latency and streaming.
        rst_n = 1'b1;
        a = 2'd2; b = 2'd2;
        tick();
        check("pipe 2x2 q", 8'(out_q), 8'b0100);
        check("pipe 2x2 v", 8'(out_valid), 8'd1);
        a = 2'd1; b = 2'd3;
        tick();
        check("stream 1x3 q", 8'(out_q), 8'b0011);
        check("stream 1x3 v", 8'(out_valid), 8'd1);
        a = 2'd3; b = 2'd1;
        tick();
        check("stream 3x1 q", 8'(out_q), 8'b0011);
        check("stream 3x1 v", 8'(out_valid), 8'd1);
        a = 2'd2; b = 2'd3;
        tick();
        check("stream 2x3 q", 8'(out_q), 8'b0110);
        check("stream 2x3 v", 8'(out_valid), 8'd1);

        // Bubble: valid drops, captured value holds.
        a = 2'd3; b = 2'd3;
        tick();
        check("bubble cap q", 8'(out_q), 8'b1001);
        in_valid = 1'b0;
        a = 2'd1; b = 2'd1;
        #1;
        check("bubble out", 8'(out), 8'b0001);
        tick();
        check("bubble v", 8'(out_valid), 8'd0);
        check("bubble hold q", 8'(out_q), 8'b1001);
        check("bubble out2", 8'(out), 8'b0001);

        // Mid-stream reset discards captured result.
        in_valid = 1'b1;
        a = 2'd3; b = 2'd2;
        tick();
        check("mid cap q", 8'(out_q), 8'b0110);
        check("mid cap v", 8'(out_valid), 8'd1);
        rst_n = 1'b0;
        tick();
        check("mid rst q", 8'(out_q), 8'b0000);
        check("mid rst v", 8'(out_valid), 8'd0);
        rst_n = 1'b1;
        a = 2'd1; b = 2'd2;
        tick();
        check("resume q", 8'(out_q), 8'b0010);
        check("resume v", 8'(out_valid), 8'd1);
        in_valid = 1'b0;
        tick();
        check("drain v", 8'(out_valid), 8'd0);
        check("drain q", 8'(out_q), 8'b0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_x2_accurate_mul
